// File: rtl/encoder16x4_seq.sv
// encoder16x4_seq: sequential 16-to-4 request encoder with a pending register,
// a two-state valid/ready output stage and a sticky overflow flag.
// Optional feature: define ENC_ROUND_ROBIN_EN to replace fixed lowest-index
// priority with rotating priority that starts after the last granted index.
module encoder16x4_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] d,
  input  logic        out_ready,
  output logic [3:0]  i,
  output logic        valid,
  output logic        ovf
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [15:0] pend_reg, pend_next;
  logic [3:0]  i_reg, i_next;
  logic        ovf_reg, ovf_next;
  logic        handshake;
  logic [15:0] clr;
  logic [15:0] captured;
  logic [15:0] remain;
  logic [15:0] pick_src;
  logic [3:0]  pick_idx;

`ifdef ENC_ROUND_ROBIN_EN
  logic [3:0]  last_reg, last_next;
  logic [3:0]  start_idx;
`endif

  assign handshake = (state_reg == HOLD) && out_ready;
  assign captured  = en ? d : 16'h0000;
  // Only requests already pending before this edge are eligible for a load;
  // bits arriving with d on this edge are picked up on the following edge.
  assign remain    = pend_reg & ~clr;

  // One-hot clear of the index being handed off this cycle.
  always_comb begin
    clr = 16'h0000;
    if (handshake) begin
      clr[i_reg] = 1'b1;
    end
  end

  // Pending update: set from d wins over a same-edge clear; overflow when a
  // captured bit lands on a bit that stays pending.
  always_comb begin
    pend_next = remain | captured;
    ovf_next  = ovf_reg | (|(captured & remain));
  end

  // Source vector for the priority search: full pend when idle, remainder
  // after the current handoff when holding.
  always_comb begin
    pick_src = (state_reg == HOLD) ? remain : pend_reg;
  end

`ifdef ENC_ROUND_ROBIN_EN
  assign start_idx = last_reg + 4'd1;

  // Rotating priority: first set bit at or after start_idx, wrapping 15->0.
  always_comb begin
    logic       found;
    logic [3:0] idx;
    found    = 1'b0;
    pick_idx = 4'h0;
    idx      = 4'h0;
    for (int k = 0; k < 16; k++) begin
      idx = start_idx + k[3:0];
      if (!found && pick_src[idx]) begin
        pick_idx = idx;
        found    = 1'b1;
      end
    end
  end

  // Pointer follows every completed handoff.
  always_comb begin
    last_next = last_reg;
    if (handshake) begin
      last_next = i_reg;
    end
  end
`else
  // Fixed priority: lowest set index wins (scan high to low, last hit sticks).
  always_comb begin
    pick_idx = 4'h0;
    for (int k = 15; k >= 0; k--) begin
      if (pick_src[k]) begin
        pick_idx = k[3:0];
      end
    end
  end
`endif

  // Output stage next-state: load on pending work, hold while stalled,
  // chain back-to-back grants or drop to IDLE after the last handoff.
  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    case (state_reg)
      IDLE: begin
        if (pend_reg != 16'h0000) begin
          state_next = HOLD;
          i_next     = pick_idx;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (remain != 16'h0000) begin
            i_next = pick_idx;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pend_reg  <= 16'h0000;
      i_reg     <= 4'h0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      i_reg     <= i_next;
      ovf_reg   <= ovf_next;
    end
  end

`ifdef ENC_ROUND_ROBIN_EN
  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= 4'h0;
    end else begin
      last_reg <= last_next;
    end
  end
`endif

  assign i     = i_reg;
  assign valid = (state_reg == HOLD);
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_encoder16x4_seq.sv
// Directed testbench for encoder16x4_seq (default fixed-priority build).
module tb_encoder16x4_seq;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] d;
  logic        out_ready;
  logic [3:0]  i;
  logic        valid;
  logic        ovf;

  int n_cmp = 0;
  int n_bad = 0;

  encoder16x4_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .d         (d),
    .out_ready (out_ready),
    .i         (i),
    .valid     (valid),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; d = 16'h0000; out_ready = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (valid !== 1'b0 || i !== 4'h0 || ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: valid=%b i=%h ovf=%b want 0/0/0", valid, i, ovf);
    end
    $display("reset: valid=%b i=%h ovf=%b", valid, i, ovf);
  endtask

  // One request, ready high: valid two edges after capture, one cycle long.
  task automatic test_single();
    do_reset();
    out_ready = 1'b1; en = 1'b1; d = 16'h0008;
    tick();
    en = 1'b0; d = 16'h0000;
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL single_lat1: valid=%b want 0", valid);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b1 || i !== 4'h3) begin
      n_bad++; $display("FAIL single_load: valid=%b i=%h want 1/3", valid, i);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL single_drop: valid=%b want 0", valid);
    end
    $display("single d=0008: done");
  endtask

  // Two requests drained back to back in priority order.
  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1; en = 1'b1; d = 16'h8001;
    tick();
    en = 1'b0; d = 16'h0000;
    tick();
    n_cmp++;
    if (valid !== 1'b1 || i !== 4'h0) begin
      n_bad++; $display("FAIL b2b_first: valid=%b i=%h want 1/0", valid, i);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b1 || i !== 4'hF) begin
      n_bad++; $display("FAIL b2b_second: valid=%b i=%h want 1/f", valid, i);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_drop: valid=%b want 0", valid);
    end
    $display("back_to_back d=8001: done");
  endtask

  // Stalled consumer holds the grant steady.
  task automatic test_stall();
    do_reset();
    out_ready = 1'b0; en = 1'b1; d = 16'h0010;
    tick();
    en = 1'b0; d = 16'h0000;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (valid !== 1'b1 || i !== 4'h4) begin
        n_bad++; $display("FAIL stall_hold%0d: valid=%b i=%h want 1/4", k, valid, i);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_release: valid=%b want 0", valid);
    end
    $display("stall d=0010: done");
  endtask

  // Re-request of a pending bit sets sticky overflow.
  task automatic test_ovf();
    do_reset();
    out_ready = 1'b0; en = 1'b1; d = 16'h0004;
    tick();
    en = 1'b0; d = 16'h0000;
    tick();
    n_cmp++;
    if (ovf !== 1'b0 || valid !== 1'b1 || i !== 4'h2) begin
      n_bad++; $display("FAIL ovf_pre: ovf=%b valid=%b i=%h want 0/1/2", ovf, valid, i);
    end
    en = 1'b1; d = 16'h0004;
    tick();
    en = 1'b0; d = 16'h0000;
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_bad++; $display("FAIL ovf_set: ovf=%b want 1", ovf);
    end
    out_ready = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (ovf !== 1'b1 || valid !== 1'b0) begin
      n_bad++; $display("FAIL ovf_sticky: ovf=%b valid=%b want 1/0", ovf, valid);
    end
    $display("ovf d=0004 twice: done");
  endtask

  // Same-edge set and clear: set wins, no overflow, bit re-granted later.
  task automatic test_set_wins();
    do_reset();
    out_ready = 1'b0; en = 1'b1; d = 16'h0020;
    tick();
    en = 1'b0; d = 16'h0000;
    tick();
    out_ready = 1'b1; en = 1'b1; d = 16'h0020;
    tick();
    en = 1'b0; d = 16'h0000;
    n_cmp++;
    if (valid !== 1'b0 || ovf !== 1'b0) begin
      n_bad++; $display("FAIL setwins_hs: valid=%b ovf=%b want 0/0", valid, ovf);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b1 || i !== 4'h5) begin
      n_bad++; $display("FAIL setwins_regrant: valid=%b i=%h want 1/5", valid, i);
    end
    tick();
    $display("set_wins d=0020: done");
  endtask

  // All-zero input with nothing pending stays idle, i unchanged (last was 5).
  task automatic test_idle_zero();
    en = 1'b1; d = 16'h0000; out_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if (valid !== 1'b0 || i !== 4'h5) begin
      n_bad++; $display("FAIL idle_zero: valid=%b i=%h want 0/5", valid, i);
    end
    en = 1'b0;
    $display("idle_zero: done");
  endtask

  // Asynchronous reset in HOLD clears everything before the next edge.
  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0; en = 1'b1; d = 16'h00F0;
    tick();
    d = 16'h0010;
    tick();
    en = 1'b0; d = 16'h0000;
    n_cmp++;
    if (valid !== 1'b1 || i !== 4'h4 || ovf !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_pre: valid=%b i=%h ovf=%b want 1/4/1", valid, i, ovf);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (valid !== 1'b0 || i !== 4'h0 || ovf !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_async: valid=%b i=%h ovf=%b want 0/0/0", valid, i, ovf);
    end
    #10;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_pend_gone: valid=%b want 0", valid);
    end
    en = 1'b1; d = 16'h0001;
    tick();
    en = 1'b0; d = 16'h0000;
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_lat1: valid=%b want 0", valid);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b1 || i !== 4'h0) begin
      n_bad++; $display("FAIL rstmid_load: valid=%b i=%h want 1/0", valid, i);
    end
    $display("reset_mid d=00F0: done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_ovf();
    test_set_wins();
    test_idle_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim time exceeded limit");
    $fatal(1, "timeout");
  end

endmodule
